vpu_opget: RTL and testbench

Per-read-port operand fetch engine of the VPU. On a start command it issues `OPGET_BEATS` sequential SRAM reads from a base address and pushes each returned line into the operand queue. It then raises a sticky `done_o`, which feeds one bit of the controller's `opget_done_i` vector, and holds it until the controller's `reset_cmd` clears it. One instance exists per SRAM read port (`SRAM_R_PORT_CNT`).

---
 rtl/vpu_opget_pkg.sv | 16 +
 rtl/vpu_opget_if.sv | 23 ++
 rtl/vpu_opget_addr_gen.sv | 54 +++++
 rtl/vpu_opget.sv | 113 +++++++++++
 tb/tb_vpu_opget.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/vpu_opget_pkg.sv
// rtl/vpu_opget_pkg.sv - shared VPU constants and operand-fetch state encoding
package vpu_opget_pkg;

    localparam int SRAM_R_PORT_CNT = 2;
    localparam int SRAM_ADDR_W     = 10;
    localparam int SRAM_DATA_W     = 256;
    localparam int OPGET_BEATS     = 2;

    typedef enum logic [1:0] {
        S_OG_IDLE  = 2'd0,
        S_OG_FETCH = 2'd1,
        S_OG_DRAIN = 2'd2,
        S_OG_DONE  = 2'd3
    } opget_state_t;

endpackage

// File: rtl/vpu_opget_if.sv
// rtl/vpu_opget_if.sv - SRAM read port and operand-queue push bundle
interface vpu_opget_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 256
);
    logic              sram_rden;
    logic [ADDR_W-1:0] sram_raddr;
    logic [DATA_W-1:0] sram_rdata;
    logic              oq_full;
    logic              oq_afull;
    logic              oq_wren;
    logic [DATA_W-1:0] oq_wdata;

    modport master (
        output sram_rden, sram_raddr, oq_wren, oq_wdata,
        input  sram_rdata, oq_full, oq_afull
    );

    modport slave (
        input  sram_rden, sram_raddr, oq_wren, oq_wdata,
        output sram_rdata, oq_full, oq_afull
    );
endinterface

// File: rtl/vpu_opget_addr_gen.sv
// rtl/vpu_opget_addr_gen.sv - base/stride latch, issue counter and wrapping line-address adder
module vpu_opget_addr_gen #(
    parameter int ADDR_W      = 10,
    parameter int OPGET_BEATS = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic              advance_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [ADDR_W-1:0] stride_i,
    output logic [ADDR_W-1:0] raddr_o,
    output logic              last_issue_o
);
    localparam int CNT_W = $clog2(OPGET_BEATS + 1);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] stride_q, stride_d;
    logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;

    // Running sum equals base + issue_cnt * stride; ADDR_W-bit add wraps on its own.
    always_comb begin
        addr_d      = addr_q;
        stride_d    = stride_q;
        issue_cnt_d = issue_cnt_q;
        if (clear_i) begin
            issue_cnt_d = '0;
        end else if (load_i) begin
            addr_d      = base_i;
            stride_d    = stride_i;
            issue_cnt_d = '0;
        end else if (advance_i) begin
            addr_d      = addr_q + stride_q;
            issue_cnt_d = issue_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q      <= '0;
            stride_q    <= '0;
            issue_cnt_q <= '0;
        end else begin
            addr_q      <= addr_d;
            stride_q    <= stride_d;
            issue_cnt_q <= issue_cnt_d;
        end
    end

    assign raddr_o      = addr_q;
    assign last_issue_o = (issue_cnt_q == CNT_W'(OPGET_BEATS - 1));

endmodule

// File: rtl/vpu_opget.sv
// rtl/vpu_opget.sv - per-read-port operand fetch engine; VPU_OPGET_STRIDE_EN adds stride_i
module vpu_opget #(
    parameter int ADDR_W      = vpu_opget_pkg::SRAM_ADDR_W,
    parameter int DATA_W      = vpu_opget_pkg::SRAM_DATA_W,
    parameter int OPGET_BEATS = vpu_opget_pkg::OPGET_BEATS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
`ifdef VPU_OPGET_STRIDE_EN
    input  logic [ADDR_W-1:0] stride_i,
`endif
    input  logic              reset_cmd_i,
    vpu_opget_if.master       bus,
    output logic              busy_o,
    output logic              done_o
);
    import vpu_opget_pkg::*;

    localparam int CNT_W = $clog2(OPGET_BEATS + 1);

    opget_state_t      state_q, state_d;
    logic [CNT_W-1:0]  push_cnt_q, push_cnt_d;
    logic              inflight_q, inflight_d;
    logic              done_q, done_d;
    logic              rden, wren, load, last_issue;
    logic [ADDR_W-1:0] raddr, stride_sel;

`ifdef VPU_OPGET_STRIDE_EN
    assign stride_sel = stride_i;
`else
    assign stride_sel = ADDR_W'(1);
`endif

    vpu_opget_addr_gen #(
        .ADDR_W      (ADDR_W),
        .OPGET_BEATS (OPGET_BEATS)
    ) u_addr_gen (
        .clk          (clk),
        .rst          (rst),
        .load_i       (load),
        .clear_i      (reset_cmd_i),
        .advance_i    (rden),
        .base_i       (base_addr_i),
        .stride_i     (stride_sel),
        .raddr_o      (raddr),
        .last_issue_o (last_issue)
    );

    // A second read may overlap an in-flight one only if the queue has two free slots.
    always_comb begin
        state_d    = state_q;
        push_cnt_d = push_cnt_q;
        done_d     = done_q;
        inflight_d = 1'b0;
        rden       = 1'b0;
        wren       = 1'b0;
        load       = 1'b0;
        if (reset_cmd_i) begin
            state_d    = S_OG_IDLE;
            push_cnt_d = '0;
            done_d     = 1'b0;
        end else begin
            wren = inflight_q;
            if (wren) push_cnt_d = push_cnt_q + 1'b1;
            case (state_q)
                S_OG_IDLE: begin
                    if (start_i) begin
                        load       = 1'b1;
                        push_cnt_d = '0;
                        state_d    = S_OG_FETCH;
                    end
                end
                S_OG_FETCH: begin
                    rden = inflight_q ? !bus.oq_afull : !bus.oq_full;
                    if (rden && last_issue) state_d = S_OG_DRAIN;
                end
                S_OG_DRAIN: begin
                    if (wren && push_cnt_q == CNT_W'(OPGET_BEATS - 1)) begin
                        state_d = S_OG_DONE;
                        done_d  = 1'b1;
                    end
                end
                S_OG_DONE: state_d = S_OG_DONE;
                default:   state_d = S_OG_IDLE;
            endcase
            inflight_d = rden;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_OG_IDLE;
            push_cnt_q <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            push_cnt_q <= push_cnt_d;
            inflight_q <= inflight_d;
            done_q     <= done_d;
        end
    end

    assign bus.sram_rden  = rden;
    assign bus.sram_raddr = raddr;
    assign bus.oq_wren    = wren;
    assign bus.oq_wdata   = wren ? bus.sram_rdata : '0;
    assign busy_o         = (state_q == S_OG_FETCH) || (state_q == S_OG_DRAIN);
    assign done_o         = done_q;

endmodule

// File: tb/tb_vpu_opget.sv
// tb/tb_vpu_opget.sv - directed self-checking bench for vpu_opget
module tb_vpu_opget;
    logic       clk = 1'b0;
    logic       rst;
    logic       start_i;
    logic [9:0] base_addr_i;
    logic       reset_cmd_i;
    logic       busy_o, done_o;
`ifdef VPU_OPGET_STRIDE_EN
    logic [9:0] stride_i;
`endif
    int n_chk = 0;
    int n_err = 0;

    vpu_opget_if #(.ADDR_W(10), .DATA_W(256)) bus ();

    vpu_opget #(.ADDR_W(10), .DATA_W(256), .OPGET_BEATS(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .base_addr_i (base_addr_i),
`ifdef VPU_OPGET_STRIDE_EN
        .stride_i    (stride_i),
`endif
        .reset_cmd_i (reset_cmd_i),
        .bus         (bus),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] model(input logic [9:0] a);
        return {8{{22'h15A5A5, a}}};
    endfunction

    initial bus.sram_rdata = '0;
    always @(posedge clk) if (bus.sram_rden) bus.sram_rdata <= model(bus.sram_raddr);

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_cmd();
        reset_cmd_i = 1'b1;
        tick();
        reset_cmd_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start_i = 1'b0; base_addr_i = '0; reset_cmd_i = 1'b0;
        bus.oq_full = 1'b0; bus.oq_afull = 1'b0;
`ifdef VPU_OPGET_STRIDE_EN
        stride_i = 10'd1;
`endif
        tick(); tick();
        n_chk++;
        if ({bus.sram_rden, bus.sram_raddr, bus.oq_wren, busy_o, done_o} !== 14'd0 || bus.oq_wdata !== '0) begin
            n_err++;
            $display("FAIL reset_outputs act rd=%b ra=%h wr=%b busy=%b done=%b exp all 0",
                     bus.sram_rden, bus.sram_raddr, bus.oq_wren, busy_o, done_o);
        end
        rst = 1'b0;
        tick();
        n_chk++;
        if ({bus.sram_rden, bus.oq_wren, busy_o, done_o} !== 4'd0) begin
            n_err++;
            $display("FAIL reset_idle act rd=%b wr=%b busy=%b done=%b exp 0",
                     bus.sram_rden, bus.oq_wren, busy_o, done_o);
        end
    endtask

    // Reads in cycles 1-2, pushes in cycles 2-3, done from cycle 4, cleared one cycle after reset_cmd.
    task automatic test_nostall(input logic [9:0] base, input string name);
        logic e_rd, e_wr, e_busy, e_done;
        logic [9:0] e_ra, e_wa;
        start_i = 1'b1; base_addr_i = base;
        for (int c = 1; c <= 4; c++) begin
            tick();
            start_i = 1'b0; base_addr_i = 10'h2AA;
            #1;
            e_rd = (c == 1 || c == 2); e_ra = base + 10'(c - 1);
            e_wr = (c == 2 || c == 3); e_wa = base + 10'(c - 2);
            e_busy = (c < 4); e_done = (c == 4);
            n_chk++;
            if (bus.sram_rden !== e_rd || (e_rd && bus.sram_raddr !== e_ra)) begin
                n_err++;
                $display("FAIL %s_read c%0d act rd=%b ra=%h exp rd=%b ra=%h", name, c, bus.sram_rden, bus.sram_raddr, e_rd, e_ra);
            end
            n_chk++;
            if (bus.oq_wren !== e_wr || (e_wr && bus.oq_wdata !== model(e_wa))) begin
                n_err++;
                $display("FAIL %s_push c%0d act wr=%b d=%h exp wr=%b d=%h", name, c, bus.oq_wren, bus.oq_wdata, e_wr, model(e_wa));
            end
            n_chk++;
            if ({busy_o, done_o} !== {e_busy, e_done}) begin
                n_err++;
                $display("FAIL %s_flags c%0d act busy/done=%b%b exp %b%b", name, c, busy_o, done_o, e_busy, e_done);
            end
        end
        clear_cmd();
        #1;
        n_chk++;
        if ({busy_o, done_o} !== 2'b00) begin
            n_err++;
            $display("FAIL %s_done_clear act busy/done=%b%b exp 00", name, busy_o, done_o);
        end
    endtask

    task automatic test_afull();
        logic e_rd, e_wr;
        logic [9:0] e_ra, e_wa;
        bus.oq_afull = 1'b1;
        start_i = 1'b1; base_addr_i = 10'h040;
        for (int c = 1; c <= 5; c++) begin
            tick();
            start_i = 1'b0;
            #1;
            e_rd = (c == 1 || c == 3); e_ra = (c == 3) ? 10'h041 : 10'h040;
            e_wr = (c == 2 || c == 4); e_wa = (c == 4) ? 10'h041 : 10'h040;
            n_chk++;
            if (bus.sram_rden !== e_rd || (e_rd && bus.sram_raddr !== e_ra)) begin
                n_err++;
                $display("FAIL afull_read c%0d act rd=%b ra=%h exp rd=%b ra=%h", c, bus.sram_rden, bus.sram_raddr, e_rd, e_ra);
            end
            n_chk++;
            if (bus.oq_wren !== e_wr || (e_wr && bus.oq_wdata !== model(e_wa))) begin
                n_err++;
                $display("FAIL afull_push c%0d act wr=%b d=%h exp wr=%b d=%h", c, bus.oq_wren, bus.oq_wdata, e_wr, model(e_wa));
            end
        end
        n_chk++;
        if (done_o !== 1'b1) begin
            n_err++;
            $display("FAIL afull_done act %b exp 1", done_o);
        end
        bus.oq_afull = 1'b0;
        clear_cmd();
    endtask

    task automatic test_full();
        logic e_rd, e_wr;
        logic [9:0] e_ra, e_wa;
        start_i = 1'b1; base_addr_i = 10'h080;
        for (int c = 1; c <= 9; c++) begin
            tick();
            start_i = 1'b0;
            bus.oq_full = (c <= 5);
            #1;
            e_rd = (c == 6 || c == 7); e_ra = 10'h080 + 10'(c - 6);
            e_wr = (c == 7 || c == 8); e_wa = 10'h080 + 10'(c - 7);
            n_chk++;
            if (bus.sram_rden !== e_rd || (e_rd && bus.sram_raddr !== e_ra)) begin
                n_err++;
                $display("FAIL full_read c%0d act rd=%b ra=%h exp rd=%b ra=%h", c, bus.sram_rden, bus.sram_raddr, e_rd, e_ra);
            end
            n_chk++;
            if (bus.oq_wren !== e_wr || (e_wr && bus.oq_wdata !== model(e_wa))) begin
                n_err++;
                $display("FAIL full_push c%0d act wr=%b d=%h exp wr=%b d=%h", c, bus.oq_wren, bus.oq_wdata, e_wr, model(e_wa));
            end
        end
        n_chk++;
        if (done_o !== 1'b1) begin
            n_err++;
            $display("FAIL full_done act %b exp 1", done_o);
        end
        clear_cmd();
    endtask

    task automatic test_abort();
        start_i = 1'b1; base_addr_i = 10'h020;
        tick();
        start_i = 1'b0;
        #1;
        n_chk++;
        if (bus.sram_rden !== 1'b1 || bus.sram_raddr !== 10'h020) begin
            n_err++;
            $display("FAIL abort_first_read act rd=%b ra=%h exp rd=1 ra=020", bus.sram_rden, bus.sram_raddr);
        end
        tick();
        reset_cmd_i = 1'b1;
        #1;
        n_chk++;
        if ({bus.sram_rden, bus.oq_wren} !== 2'b00) begin
            n_err++;
            $display("FAIL abort_drop act rd=%b wr=%b exp 00", bus.sram_rden, bus.oq_wren);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            reset_cmd_i = 1'b0;
            #1;
            n_chk++;
            if ({bus.sram_rden, bus.oq_wren, busy_o, done_o} !== 4'b0000) begin
                n_err++;
                $display("FAIL abort_idle c%0d act rd=%b wr=%b busy=%b done=%b exp 0000", c, bus.sram_rden, bus.oq_wren, busy_o, done_o);
            end
        end
        test_nostall(10'h200, "restart");
    endtask

    task automatic test_ignore_start();
        start_i = 1'b1; base_addr_i = 10'h0A0;
        tick();
        start_i = 1'b0;
        tick(); tick(); tick();
        start_i = 1'b1; base_addr_i = 10'h155;
        tick();
        start_i = 1'b0;
        #1;
        n_chk++;
        if ({bus.sram_rden, busy_o, done_o} !== 3'b001) begin
            n_err++;
            $display("FAIL ignore_in_done act rd=%b busy=%b done=%b exp 001", bus.sram_rden, busy_o, done_o);
        end
        start_i = 1'b1; reset_cmd_i = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            start_i = 1'b0; reset_cmd_i = 1'b0;
            #1;
            n_chk++;
            if ({bus.sram_rden, busy_o, done_o} !== 3'b000) begin
                n_err++;
                $display("FAIL ignore_with_cmd c%0d act rd=%b busy=%b done=%b exp 000", c, bus.sram_rden, busy_o, done_o);
            end
        end
    endtask

`ifdef VPU_OPGET_STRIDE_EN
    task automatic test_stride(input logic [9:0] base, input logic [9:0] stride, input logic [9:0] a1);
        start_i = 1'b1; base_addr_i = base; stride_i = stride;
        tick();
        start_i = 1'b0; stride_i = 10'h3C3;
        #1;
        n_chk++;
        if (bus.sram_rden !== 1'b1 || bus.sram_raddr !== base) begin
            n_err++;
            $display("FAIL stride_read0 act rd=%b ra=%h exp rd=1 ra=%h", bus.sram_rden, bus.sram_raddr, base);
        end
        tick();
        #1;
        n_chk++;
        if (bus.sram_rden !== 1'b1 || bus.sram_raddr !== a1) begin
            n_err++;
            $display("FAIL stride_read1 act rd=%b ra=%h exp rd=1 ra=%h", bus.sram_rden, bus.sram_raddr, a1);
        end
        tick(); tick();
        clear_cmd();
    endtask
`endif

    initial begin
        test_reset();
        test_nostall(10'h010, "basic");
        test_nostall(10'h3FF, "wrap");
        test_afull();
        test_full();
        test_abort();
        test_ignore_start();
`ifdef VPU_OPGET_STRIDE_EN
        test_stride(10'h100, 10'h020, 10'h120);
        test_stride(10'h100, 10'h000, 10'h100);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
